// File: rtl/crypto_sched.sv
// Round-robin scheduler streaming 128-bit blocks from 8 lanes through a cipher engine, writing results in place.
// Optional engine-wait timeout: define CRYPTO_SCHED_TIMEOUT_EN.
module crypto_sched #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        req_valid,
  input  logic [LANES-1:0][31:0]  req_base,
  input  logic [LANES-1:0][5:0]   req_len,
  output logic                    rd_en,
  output logic [31:0]             rd_addr,
  output logic [2:0]              rd_lane,
  input  logic [127:0]            rd_data,
  output logic                    eng_in_valid,
  output logic [127:0]            eng_in_data,
  input  logic                    eng_in_ready,
  input  logic                    eng_out_valid,
  input  logic [127:0]            eng_out_data,
  output logic                    eng_out_ready,
  output logic                    wr_en,
  output logic [31:0]             wr_addr,
  output logic [2:0]              wr_lane,
  output logic [127:0]            wr_data,
  output logic [LANES-1:0]        done,
  output logic [LANES-1:0]        err,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    PUSH = 3'd3,
    WAIT = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [2:0]         rr_ptr, rr_n;
  logic [2:0]         lane, lane_n;
  logic [31:0]        cur_addr, addr_n;
  logic [5:0]         remaining, rem_n;
  logic [127:0]       hold, hold_n;
  logic [127:0]       result, result_n;
  logic [LANES-1:0]   done_q, done_n;
  logic               found;
  logic [2:0]         pick;
  logic [2:0]         cand;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0]      tmo_cnt;
  logic [LANES-1:0]   err_q, err_n;
  logic               tmo_hit;

  assign tmo_hit = ((state == PUSH) || (state == WAIT)) && (tmo_cnt == TW'(TMO_CYC - 1));
`endif

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = rr_ptr + 3'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    lane_n   = lane;
    addr_n   = cur_addr;
    rem_n    = remaining;
    hold_n   = hold;
    result_n = result;
    done_n   = '0;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
    err_n    = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          lane_n  = pick;
          addr_n  = req_base[pick];
          rem_n   = req_len[pick];
          rr_n    = pick + 3'd1;
          state_n = (req_len[pick] == 6'd0) ? DONE : RD;
        end
      end
      RD:   state_n = LAT;
      LAT: begin
        hold_n  = rd_data;
        state_n = PUSH;
      end
      PUSH: if (eng_in_ready) state_n = WAIT;
      WAIT: begin
        if (eng_out_valid) begin
          result_n = eng_out_data;
          state_n  = WR;
        end
      end
      WR: begin
        addr_n  = cur_addr + 32'd16;
        rem_n   = remaining - 6'd1;
        state_n = (remaining == 6'd1) ? DONE : RD;
      end
      DONE: begin
        done_n[lane] = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef CRYPTO_SCHED_TIMEOUT_EN
    // Timeout wins over a same-cycle handshake so the abort is deterministic.
    if (tmo_hit) begin
      err_n[lane] = 1'b1;
      result_n    = result;
      state_n     = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lane      <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      hold      <= '0;
      result    <= '0;
      done_q    <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      lane      <= lane_n;
      cur_addr  <= addr_n;
      remaining <= rem_n;
      hold      <= hold_n;
      result    <= result_n;
      done_q    <= done_n;
    end
  end

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else begin
      err_q   <= err_n;
      if (((state == PUSH) || (state == WAIT)) && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

  // Strobes decode the registered state; buses come straight from registers, so reset zeroes every output.
  assign rd_en         = (state == RD);
  assign rd_addr       = cur_addr;
  assign rd_lane       = lane;
  assign eng_in_valid  = (state == PUSH);
  assign eng_in_data   = hold;
  assign eng_out_ready = (state == WAIT);
  assign wr_en         = (state == WR);
  assign wr_addr       = cur_addr;
  assign wr_lane       = lane;
  assign wr_data       = result;
  assign done          = done_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_crypto_sched.sv
// Directed self-checking bench for crypto_sched; buffer and engine are behavioural models.
module tb_crypto_sched;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        req_valid;
  logic [7:0][31:0]  req_base;
  logic [7:0][5:0]   req_len;
  logic              rd_en;
  logic [31:0]       rd_addr;
  logic [2:0]        rd_lane;
  logic [127:0]      rd_data;
  logic              eng_in_valid;
  logic [127:0]      eng_in_data;
  logic              eng_in_ready;
  logic              eng_out_valid;
  logic [127:0]      eng_out_data;
  logic              eng_out_ready;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [2:0]        wr_lane;
  logic [127:0]      wr_data;
  logic [7:0]        done;
  logic [7:0]        err;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int eng_xfers = 0;
  logic [127:0] eng_buf = '0;

  localparam logic [127:0] KEY = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  crypto_sched #(.LANES(8), .TMO_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_base(req_base), .req_len(req_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane), .rd_data(rd_data),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_in_ready(eng_in_ready),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .eng_out_ready(eng_out_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data),
    .done(done), .err(err), .busy(busy)
  );

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h11};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_addr);
  always @(posedge clk) begin
    if (eng_in_valid && eng_in_ready) begin
      eng_buf   <= eng_in_data;
      eng_xfers <= eng_xfers + 1;
    end
  end
  assign eng_out_data = eng_buf ^ KEY;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, eng_in_valid, eng_out_ready, wr_en, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got=%b expected=00000", {rd_en, eng_in_valid, eng_out_ready, wr_en, busy});
    end
    checks++;
    if ({done, err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_done_err: got=%h expected=0000", {done, err});
    end
    checks++;
    if ({rd_addr, wr_addr, eng_in_data, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_buses: rd_addr=%h wr_addr=%h expected all zero", rd_addr, wr_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int rd_n = 0, wr_n = 0, done_n = 0, done_cyc = -1, first_rd = -1;
    logic [31:0] rd_a [2];
    logic [31:0] exp_a;
    rd_a[0] = '0; rd_a[1] = '0;
    req_base[3] = 32'h1000; req_len[3] = 6'd2; req_valid[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin req_base[3] = 32'hDEAD_0000; req_len[3] = 6'd9; end
      if (rd_en) begin
        if (rd_n < 2) rd_a[rd_n] = rd_addr;
        if (first_rd < 0) first_rd = k;
        checks++;
        if (rd_lane !== 3'd3) begin
          failures++;
          $display("FAIL basic_rd_lane: got=%0d expected=3", rd_lane);
        end
        rd_n++;
      end
      if (wr_en) begin
        exp_a = 32'h1000 + 32'(wr_n * 16);
        checks++;
        if (wr_addr !== exp_a || wr_data !== (mem_word(exp_a) ^ KEY) || wr_lane !== 3'd3) begin
          failures++;
          $display("FAIL basic_wr%0d: addr=%h data=%h lane=%0d expected addr=%h data=%h lane=3",
                   wr_n, wr_addr, wr_data, wr_lane, exp_a, mem_word(exp_a) ^ KEY);
        end
        wr_n++;
      end
      if (done !== 8'h00) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
        checks++;
        if (done !== 8'h08) begin
          failures++;
          $display("FAIL basic_done_lane: got=%h expected=08", done);
        end
        req_valid[3] = 1'b0;
      end
    end
    checks++;
    if (rd_n != 2 || rd_a[0] !== 32'h1000 || rd_a[1] !== 32'h1010) begin
      failures++;
      $display("FAIL basic_reads: count=%0d a0=%h a1=%h expected count=2 a0=00001000 a1=00001010", rd_n, rd_a[0], rd_a[1]);
    end
    checks++;
    if (first_rd != 1) begin
      failures++;
      $display("FAIL basic_first_rd: cycle=%0d expected=1", first_rd);
    end
    checks++;
    if (wr_n != 2) begin
      failures++;
      $display("FAIL basic_wr_count: got=%0d expected=2", wr_n);
    end
    checks++;
    if (done_cyc != 12 || done_n != 1) begin
      failures++;
      $display("FAIL basic_done_timing: cycle=%0d pulses=%0d expected cycle=12 pulses=1", done_cyc, done_n);
    end
    req_base[3] = '0; req_len[3] = '0;
  endtask

  task automatic test_rr();
    int got = 0;
    int lanes [4];
    int exp_l [4] = '{0, 2, 7, 0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_len[0] = 6'd0; req_len[2] = 6'd0; req_len[7] = 6'd0;
    req_valid = 8'h85;
    for (int k = 1; k <= 30 && got < 4; k++) begin
      @(negedge clk);
      if (done !== 8'h00) begin
        lanes[got] = -1;
        for (int b = 0; b < 8; b++) if (done[b]) lanes[got] = b;
        got++;
        if (got == 4) req_valid = 8'h00;
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (g >= got || lanes[g] != exp_l[g]) begin
        failures++;
        $display("FAIL rr_grant%0d: got=%0d expected=%0d (pulses seen=%0d)", g, (g < got) ? lanes[g] : -1, exp_l[g], got);
      end
    end
    req_valid = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_len0();
    int rw = 0, done_cyc = -1;
    logic [7:0] done_v = '0;
    logic busy1 = 1'b0;
    req_len[5] = 6'd0; req_base[5] = 32'h5000; req_valid[5] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (rd_en || wr_en) rw++;
      if (done !== 8'h00 && done_cyc < 0) begin
        done_cyc = k; done_v = done; req_valid[5] = 1'b0;
      end
    end
    checks++;
    if (rw != 0) begin
      failures++;
      $display("FAIL len0_no_access: strobes=%0d expected=0", rw);
    end
    checks++;
    if (done_cyc != 2 || done_v !== 8'h20) begin
      failures++;
      $display("FAIL len0_done: cycle=%0d done=%h expected cycle=2 done=20", done_cyc, done_v);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL len0_busy: got=%b expected=1", busy1);
    end
    req_valid[5] = 1'b0;
  endtask

  task automatic test_stall();
    int stall_n = 0, x0, done_seen = 0, wr_n = 0, err_seen = 0;
    x0 = eng_xfers;
    eng_in_ready = 1'b0;
    req_base[1] = 32'h2000; req_len[1] = 6'd1; req_valid[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err !== 8'h00) err_seen++;
      if (eng_in_valid && !eng_in_ready) begin
        stall_n++;
        checks++;
        if (eng_in_data !== mem_word(32'h2000)) begin
          failures++;
          $display("FAIL stall_data_c%0d: got=%h expected=%h", k, eng_in_data, mem_word(32'h2000));
        end
        if (stall_n == 10) eng_in_ready = 1'b1;
      end
      if (wr_en) begin
        wr_n++;
        checks++;
        if (wr_data !== (mem_word(32'h2000) ^ KEY) || wr_addr !== 32'h2000) begin
          failures++;
          $display("FAIL stall_wr: addr=%h data=%h expected addr=00002000 data=%h", wr_addr, wr_data, mem_word(32'h2000) ^ KEY);
        end
      end
      if (done !== 8'h00) begin
        done_seen++;
        req_valid[1] = 1'b0;
      end
    end
    checks++;
    if (stall_n != 10 || (eng_xfers - x0) != 1) begin
      failures++;
      $display("FAIL stall_xfer: stalled=%0d transfers=%0d expected stalled=10 transfers=1", stall_n, eng_xfers - x0);
    end
    checks++;
    if (done_seen != 1 || wr_n != 1 || err_seen != 0) begin
      failures++;
      $display("FAIL stall_complete: done=%0d writes=%0d err=%0d expected 1 1 0", done_seen, wr_n, err_seen);
    end
    eng_in_ready = 1'b1;
    req_valid[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited = 0, stray = 0;
    logic [7:0] first_done = '0;
    eng_out_valid = 1'b0;
    req_base[6] = 32'h3000; req_len[6] = 6'd1; req_valid[6] = 1'b1;
    for (int k = 1; k <= 20 && waited == 0; k++) begin
      @(negedge clk);
      if (eng_out_ready) waited = k;
    end
    checks++;
    if (waited == 0) begin
      failures++;
      $display("FAIL rstmid_reach_wait: eng_out_ready never seen within 20 cycles");
    end
    rst_n = 1'b0; req_valid[6] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, eng_in_valid, eng_out_ready, wr_en, busy, done, err} !== 21'h0 || eng_in_data !== '0 || rd_addr !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: strobes=%b done=%h err=%h rd_addr=%h expected all zero",
               {rd_en, eng_in_valid, eng_out_ready, wr_en, busy}, done, err, rd_addr);
    end
    rst_n = 1'b1; eng_out_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 8'h00 || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid_no_done: stray cycles=%0d expected=0", stray);
    end
    req_len[0] = 6'd0; req_len[7] = 6'd0; req_valid = 8'h81;
    for (int k = 1; k <= 6 && first_done == 8'h00; k++) begin
      @(negedge clk);
      if (done !== 8'h00) begin first_done = done; req_valid = 8'h00; end
    end
    checks++;
    if (first_done !== 8'h01) begin
      failures++;
      $display("FAIL rstmid_rr_restart: done=%h expected=01", first_done);
    end
    req_valid = 8'h00;
    repeat (3) @(negedge clk);
  endtask

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc = -1, wr_n = 0, done_n = 0;
    logic [7:0] err_v = '0;
    eng_out_valid = 1'b0;
    req_base[4] = 32'h4000; req_len[4] = 6'd1; req_valid[4] = 1'b1;
    for (int k = 1; k <= 270; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[4] = 1'b0;
      if (wr_en) wr_n++;
      if (done !== 8'h00) done_n++;
      if (err !== 8'h00 && err_cyc < 0) begin err_cyc = k; err_v = err; end
    end
    checks++;
    if (err_cyc != 258 || err_v !== 8'h10) begin
      failures++;
      $display("FAIL timeout_err: cycle=%0d err=%h expected cycle=258 err=10", err_cyc, err_v);
    end
    checks++;
    if (wr_n != 0 || done_n != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort: writes=%0d done=%0d busy=%b expected 0 0 0", wr_n, done_n, busy);
    end
    eng_out_valid = 1'b1;
  endtask
`else
  task automatic test_timeout();
    int err_n = 0, done_cyc = -1;
    eng_out_valid = 1'b0;
    req_base[4] = 32'h4000; req_len[4] = 6'd1; req_valid[4] = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[4] = 1'b0;
      if (err !== 8'h00) err_n++;
    end
    checks++;
    if (err_n != 0 || busy !== 1'b1 || eng_out_ready !== 1'b1) begin
      failures++;
      $display("FAIL notimeout_wait: err cycles=%0d busy=%b ready=%b expected 0 1 1", err_n, busy, eng_out_ready);
    end
    eng_out_valid = 1'b1;
    for (int k = 1; k <= 10 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (wr_en) begin
        checks++;
        if (wr_data !== (mem_word(32'h4000) ^ KEY)) begin
          failures++;
          $display("FAIL notimeout_wr: got=%h expected=%h", wr_data, mem_word(32'h4000) ^ KEY);
        end
      end
      if (done === 8'h10) done_cyc = k;
    end
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL notimeout_done: done[4] not seen within 10 cycles after engine response");
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_base = '0; req_len = '0;
    rd_data = '0;
    eng_in_ready = 1'b1;
    eng_out_valid = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_rr();
    test_len0();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
